// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start/data/parity/stop framing with a
// three-sample majority vote per bit, parity/stop/break flags, and a
// one-cycle Data_Valid pulse for each error-free frame.
//
// Handshake: there is no back-pressure. Data_Valid (or Break_Detect) is a
// one-cycle pulse in the cycle P_DATA/Parity_Error/Stop_Error first show the
// completed frame; those levels hold until the next completed frame.
module uart_rx_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Serial_Data,
   input  logic                  Parity_Enable,
   input  logic                  Parity_Type,
   input  logic                  Two_Stop,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Parity_Error,
   output logic                  Stop_Error,
   output logic                  Break_Detect,
   output logic                  Busy,
   output logic [2:0]            Dbg_State
);

   localparam int EW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
   localparam logic [EW-1:0] SAMP_A    = EW'(OVERSAMPLE / 2 - 1);
   localparam logic [EW-1:0] SAMP_B    = EW'(OVERSAMPLE / 2);
   localparam logic [EW-1:0] SAMP_C    = EW'(OVERSAMPLE / 2 + 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [EW-1:0]         edge_q, edge_d;
   logic [BW-1:0]         idx_q, idx_d;
   logic [1:0]            ones_q, ones_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  par_en_q, par_en_d;
   logic                  par_type_q, par_type_d;
   logic                  two_stop_q, two_stop_d;
   logic                  pe_q, pe_d;
   logic                  se_q, se_d;
   logic                  any_one_q, any_one_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_err_q, par_err_d;
   logic                  stop_err_q, stop_err_d;
   logic                  dv_q, dv_d;
   logic                  brk_q, brk_d;

   logic                  bit_end;
   logic                  samp_hit;
   logic [1:0]            ones_now;
   logic                  vote;
   logic                  frame_done;
   logic                  start_frame;

   // The vote includes the current sample so that small OVERSAMPLE values,
   // whose last sample edge coincides with the bit end, still see all three.
   assign bit_end     = (edge_q == EDGE_LAST);
   assign samp_hit    = (edge_q == SAMP_A) || (edge_q == SAMP_B) || (edge_q == SAMP_C);
   assign ones_now    = ones_q + {1'b0, samp_hit & Serial_Data};
   assign vote        = ones_now[1];
   assign frame_done  = bit_end && (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));
   // A low line at the final stop bit end is the next start bit already.
   assign start_frame = !Serial_Data && ((state_q == S_IDLE) || frame_done);

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decisions, all taken at the bit end except leaving IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!Serial_Data) state_d = S_START;
         S_START:  if (bit_end) state_d = vote ? S_IDLE : S_DATA;
         S_DATA:   if (bit_end && (idx_q == IDX_LAST)) state_d = par_en_q ? S_PARITY : S_STOP1;
         S_PARITY: if (bit_end) state_d = S_STOP1;
         S_STOP1:  if (bit_end) state_d = two_stop_q ? S_STOP2 : (Serial_Data ? S_IDLE : S_START);
         S_STOP2:  if (bit_end) state_d = Serial_Data ? S_IDLE : S_START;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs derived from the state register.
   always_comb begin
      Busy      = (state_q != S_IDLE);
      Dbg_State = state_q;
   end

   // Datapath next values: counters, vote accumulation, frame flags, results.
   always_comb begin
      edge_d     = edge_q;
      idx_d      = idx_q;
      ones_d     = ones_q;
      shreg_d    = shreg_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      two_stop_d = two_stop_q;
      pe_d       = pe_q;
      se_d       = se_q;
      any_one_d  = any_one_q;
      p_data_d   = p_data_q;
      par_err_d  = par_err_q;
      stop_err_d = stop_err_q;
      dv_d       = 1'b0;
      brk_d      = 1'b0;
      if (state_q == S_IDLE) begin
         edge_d = '0;
         ones_d = 2'd0;
      end else begin
         edge_d = bit_end ? '0 : edge_q + EW'(1);
         ones_d = bit_end ? 2'd0 : ones_now;
      end
      if (bit_end) begin
         case (state_q)
            S_DATA: begin
               shreg_d[idx_q] = vote;
               idx_d          = idx_q + BW'(1);
               if (vote) any_one_d = 1'b1;
            end
            S_PARITY: begin
               pe_d = vote ^ (^shreg_q) ^ par_type_q;
               if (vote) any_one_d = 1'b1;
            end
            S_STOP1, S_STOP2: begin
               if (vote) any_one_d = 1'b1;
               else      se_d      = 1'b1;
            end
            default: ;
         endcase
      end
      if (frame_done) begin
         p_data_d   = shreg_q;
         par_err_d  = pe_q;
         stop_err_d = se_q | ~vote;
         brk_d      = ~(any_one_q | vote);
         dv_d       = ~pe_q & ~se_q & vote;
      end
      if (start_frame) begin
         idx_d      = '0;
         pe_d       = 1'b0;
         se_d       = 1'b0;
         any_one_d  = 1'b0;
         par_en_d   = Parity_Enable;
         par_type_d = Parity_Type;
         two_stop_d = Two_Stop;
      end
   end

   // Datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_q     <= '0;
         idx_q      <= '0;
         ones_q     <= 2'd0;
         shreg_q    <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         two_stop_q <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
         any_one_q  <= 1'b0;
         p_data_q   <= '0;
         par_err_q  <= 1'b0;
         stop_err_q <= 1'b0;
         dv_q       <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         edge_q     <= edge_d;
         idx_q      <= idx_d;
         ones_q     <= ones_d;
         shreg_q    <= shreg_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         two_stop_q <= two_stop_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
         any_one_q  <= any_one_d;
         p_data_q   <= p_data_d;
         par_err_q  <= par_err_d;
         stop_err_q <= stop_err_d;
         dv_q       <= dv_d;
         brk_q      <= brk_d;
      end
   end

   assign P_DATA       = p_data_q;
   assign Data_Valid   = dv_q;
   assign Parity_Error = par_err_q;
   assign Stop_Error   = stop_err_q;
   assign Break_Detect = brk_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: a frame-level line driver, a per-cycle
// expectation model computed from frame contents, and one compare process.
module tb_uart_rx_engine;

   localparam int DW   = 8;
   localparam int OS   = 8;
   localparam int MAXC = 16384;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst, sd, pen, ptype, two;
   logic [DW-1:0] p_data;
   logic          dv, pe, se, brk, busy;
   logic [2:0]    dbg;
   int            cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_engine #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
      .CLK(clk), .RST(rst), .Serial_Data(sd), .Parity_Enable(pen),
      .Parity_Type(ptype), .Two_Stop(two), .P_DATA(p_data), .Data_Valid(dv),
      .Parity_Error(pe), .Stop_Error(se), .Break_Detect(brk), .Busy(busy),
      .Dbg_State(dbg)
   );

   // ---------------- model state ----------------
   typedef struct {
      logic [DW-1:0] data;
      bit pen, ptype, two, par_bit, stop1, stop2;
      int flip_bit, flip_off, abort_at;
   } frame_t;

   bit            exp_dv[MAXC], exp_brk[MAXC], exp_busy[MAXC], upd_v[MAXC];
   logic [DW-1:0] upd_pd[MAXC];
   bit            upd_pe[MAXC], upd_se[MAXC];
   logic [DW-1:0] m_pd = '0;
   bit            m_pe = 1'b0, m_se = 1'b0;
   logic [DW-1:0] exp_q[$];
   int            dv_cycles[$];
   int            n_chk = 0, n_err = 0, n_print = 0;
   bit            cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         if (n_print < 40) $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp_v);
         n_print++;
      end
   endtask

   function automatic frame_t make_frame(input logic [DW-1:0] d, input bit p_en, p_ty, t_s);
      frame_t f;
      f.data = d; f.pen = p_en; f.ptype = p_ty; f.two = t_s;
      // Even parity: total ones even; odd parity: total ones odd.
      f.par_bit = p_ty ? ~(^d) : ^d;
      f.stop1 = 1'b1; f.stop2 = 1'b1;
      f.flip_bit = -1; f.flip_off = 0; f.abort_at = -1;
      return f;
   endfunction

   function automatic int frame_bits(input frame_t f);
      return 2 + DW + int'(f.pen) + int'(f.two);
   endfunction

   function automatic bit line_bit(input frame_t f, input int b);
      int k;
      if (b == 0) return 1'b0;
      if (b <= DW) return f.data[b-1];
      k = b - 1 - DW;
      if (f.pen) begin
         if (k == 0) return f.par_bit;
         k--;
      end
      return (k == 0) ? f.stop1 : f.stop2;
   endfunction

   // Expected outputs of one frame whose start bit is driven from cycle fall.
   task automatic model_frame(input frame_t f, input int fall);
      int  n, done;
      bit  par_ok, stop_bad, all_zero;
      n    = frame_bits(f);
      done = fall + 1 + OS * n;
      for (int c = fall + 1; c <= fall + OS * n; c++) if (c < MAXC) exp_busy[c] = 1'b1;
      if (f.abort_at >= 0 || done >= MAXC) return;
      par_ok   = !f.pen || (f.par_bit == (f.ptype ? ~(^f.data) : ^f.data));
      stop_bad = !f.stop1 || (f.two && !f.stop2);
      all_zero = (f.data == '0) && (!f.pen || !f.par_bit) && !f.stop1 && (!f.two || !f.stop2);
      upd_v[done]   = 1'b1;
      upd_pd[done]  = f.data;
      upd_pe[done]  = !par_ok;
      upd_se[done]  = stop_bad;
      exp_dv[done]  = par_ok && !stop_bad;
      exp_brk[done] = all_zero;
      if (par_ok && !stop_bad) exp_q.push_back(f.data);
   endtask

   // ---------------- driver tasks ----------------
   task automatic resume();
      @(posedge clk); #1;
   endtask

   task automatic goto_neg(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      sd = 1'b1;
      repeat (n) resume();
   endtask

   task automatic drive_frame(input frame_t f, output int fall);
      int n, t;
      bit lvl;
      n = frame_bits(f);
      t = 0;
      fall = cyc;
      model_frame(f, fall);
      pen = f.pen; ptype = f.ptype; two = f.two;
      for (int b = 0; b < n; b++) begin
         lvl = line_bit(f, b);
         for (int k = 0; k < OS; k++) begin
            if (f.abort_at >= 0 && t >= f.abort_at) return;
            sd = (b == f.flip_bit && k == f.flip_off) ? ~lvl : lvl;
            if (t > 0) begin
               pen = 1'($urandom_range(0, 1)); ptype = 1'($urandom_range(0, 1));
               two = 1'($urandom_range(0, 1));
            end
            resume();
            t++;
         end
      end
   endtask

   task automatic do_reset();
      int r;
      r = cyc;
      rst = 1'b1; sd = 1'b1;
      for (int c = r + 1; c < MAXC; c++) begin
         exp_dv[c] = 1'b0; exp_brk[c] = 1'b0; exp_busy[c] = 1'b0; upd_v[c] = 1'b0;
      end
      upd_v[r+1] = 1'b1; upd_pd[r+1] = '0; upd_pe[r+1] = 1'b0; upd_se[r+1] = 1'b0;
      exp_q.delete();
      resume();
      rst = 1'b0;
   endtask

   task automatic expect_done(input string tag, input int fall, input int n, input bit e_dv,
                              input bit e_brk, input bit e_pe, input bit e_se,
                              input logic [DW-1:0] e_pd);
      sd = 1'b1;
      goto_neg(fall + OS * n);
      check({tag, "_dv_early"}, dv, 0);
      resume();
      goto_neg(fall + OS * n + 1);
      check({tag, "_dv"}, dv, e_dv);
      check({tag, "_brk"}, brk, e_brk);
      check({tag, "_perr"}, pe, e_pe);
      check({tag, "_serr"}, se, e_se);
      check({tag, "_pdata"}, p_data, e_pd);
      resume();
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (cmp_en && cyc < MAXC) begin
         if (upd_v[cyc]) begin
            m_pd = upd_pd[cyc]; m_pe = upd_pe[cyc]; m_se = upd_se[cyc];
         end
         check("data_valid", dv, exp_dv[cyc]);
         check("break_detect", brk, exp_brk[cyc]);
         check("busy", busy, exp_busy[cyc]);
         check("p_data", p_data, m_pd);
         check("parity_error", pe, m_pe);
         check("stop_error", se, m_se);
         if (dv === 1'b1) begin
            dv_cycles.push_back(cyc);
            if (exp_q.size() > 0) check("dv_word", p_data, exp_q.pop_front());
            else check("dv_unexpected", dv, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      frame_t f, f2;
      int     fall, fall2, c0, r, n, gap;

      rst = 1'b1; sd = 1'b1; pen = 1'b0; ptype = 1'b0; two = 1'b0;
      @(posedge clk); #1;
      upd_v[1] = 1'b1; upd_pd[1] = '0; upd_pe[1] = 1'b0; upd_se[1] = 1'b0;
      cmp_en = 1'b1;
      rst = 1'b0;
      goto_neg(1);
      check("rst_busy", busy, 0);
      check("rst_pdata", p_data, 0);
      resume();
      idle(5);

      // 0xA5, one flipped mid sample in data bit 2.
      f = make_frame(8'hA5, 0, 0, 0);
      f.flip_bit = 3; f.flip_off = 5;
      drive_frame(f, fall);
      check("a5_latency", cyc - fall, 80);
      expect_done("a5", fall, 10, 1, 0, 0, 0, 8'hA5);
      idle(3);

      // 0x3C even parity correct, then same line with odd parity selected.
      f = make_frame(8'h3C, 1, 0, 0);
      drive_frame(f, fall);
      expect_done("par_even", fall, 11, 1, 0, 0, 0, 8'h3C);
      idle(2);
      f.ptype = 1'b1;
      drive_frame(f, fall);
      expect_done("par_odd", fall, 11, 0, 0, 1, 0, 8'h3C);
      idle(2);

      // Start glitch: two low cycles.
      c0 = cyc;
      for (int c = c0 + 1; c <= c0 + OS; c++) exp_busy[c] = 1'b1;
      sd = 1'b0; resume(); resume(); sd = 1'b1;
      goto_neg(c0 + OS);
      check("glitch_busy_last", busy, 1);
      resume();
      goto_neg(c0 + OS + 1);
      check("glitch_busy_end", busy, 0);
      check("glitch_perr_held", pe, 1);
      check("glitch_pdata_held", p_data, 8'h3C);
      resume();
      idle(3);

      // Bad stop bit, then break.
      f = make_frame(8'h81, 0, 0, 0);
      f.stop1 = 1'b0;
      drive_frame(f, fall);
      expect_done("stop_bad", fall, 10, 0, 0, 0, 1, 8'h81);
      idle(3);
      f = make_frame(8'h00, 0, 0, 0);
      f.stop1 = 1'b0;
      drive_frame(f, fall);
      expect_done("break", fall, 10, 0, 1, 0, 1, 8'h00);
      idle(3);

      // Two stop bits, back-to-back frames.
      dv_cycles.delete();
      f  = make_frame(8'h55, 0, 0, 1);
      f2 = make_frame(8'h0F, 0, 0, 1);
      drive_frame(f, fall);
      drive_frame(f2, fall2);
      idle(OS + 4);
      if (dv_cycles.size() == 2) begin
         check("b2b_gap", dv_cycles[1] - dv_cycles[0], 88);
         check("b2b_first", dv_cycles[0] - fall, 89);
      end else begin
         check("b2b_count", dv_cycles.size(), 2);
      end
      check("b2b_last_word", p_data, 8'h0F);

      // Reset in the middle of data bit 4, then a clean frame.
      f = make_frame(8'h6B, 0, 0, 0);
      f.abort_at = OS * 5 + 4;
      drive_frame(f, fall);
      r = cyc;
      do_reset();
      goto_neg(r + 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_dv", dv, 0);
      check("rst_mid_pdata", p_data, 0);
      resume();
      idle(4);
      f = make_frame(8'hC3, 0, 0, 0);
      drive_frame(f, fall);
      expect_done("after_rst", fall, 10, 1, 0, 0, 0, 8'hC3);
      idle(3);

      // Randomized frames.
      for (int i = 0; i < 40; i++) begin
         f = make_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
         n = frame_bits(f);
         if ($urandom_range(0, 9) == 0) begin
            f = make_frame('0, f.pen, f.ptype, f.two);
            f.par_bit = 1'b0; f.stop1 = 1'b0; f.stop2 = 1'b0;
         end
         if ($urandom_range(0, 6) == 0) f.par_bit = ~f.par_bit;
         if ($urandom_range(0, 6) == 0) f.stop1 = 1'b0;
         if ($urandom_range(0, 6) == 0) f.stop2 = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            f.flip_bit = $urandom_range(0, n - 1);
            f.flip_off = $urandom_range(1, OS - 1);
         end
         drive_frame(f, fall);
         gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
         if (gap > 0) idle(gap);
      end
      idle(OS * 3);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 8, CLK cycles per bit; legal values 4, 8, 16, 32.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port Serial_Data  input  1  RX line, idle high, already synchronous to CLK.
REQ-006 SHALL have port Parity_Enable  input  1  1 = parity bit present.
REQ-007 SHALL have port Parity_Type  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port Two_Stop  input  1  1 = two stop bits expected.
REQ-009 SHALL have port P_DATA  output  DATA_WIDTH  last received word, LSB first on line.
REQ-010 SHALL have port Data_Valid  output  1  one-cycle pulse, error-free frame.
REQ-011 SHALL have port Parity_Error  output  1  level, last completed frame had parity mismatch.
REQ-012 SHALL have port Stop_Error  output  1  level, last completed frame had a 0 stop sample.
REQ-013 SHALL have port Break_Detect  output  1  one-cycle pulse, all data, parity and stop samples 0.
REQ-014 SHALL have port Busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2; edge counter 0..OVERSAMPLE-1, width clog2(OVERSAMPLE); bit index 0..DATA_WIDTH-1.
REQ-016 IDLE: Serial_Data==0 -> START next cycle, edge=0, bit index=0; Parity_Enable, Parity_Type, Two_Stop latched on this transition; mid-frame input changes ignored.
REQ-017 Edge counter SHALL increment every cycle outside IDLE and wrap from OVERSAMPLE-1 to 0 on each bit boundary.
REQ-018 Bit value SHALL be majority vote of Serial_Data at edges OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; any single flipped sample SHALL not change the result.
REQ-019 All per-bit decisions SHALL occur on the cycle edge==OVERSAMPLE-1 ("bit end").
REQ-020 START bit end: vote 1 -> IDLE (glitch, no output change, no pulses); vote 0 -> DATA.
REQ-021 DATA bit end: vote shifted into shift register at position bit index (LSB first); at index DATA_WIDTH-1 -> PARITY if latched Parity_Enable else STOP1; otherwise index+1.
REQ-022 PARITY bit end: parity error flag = vote XOR (XOR of data bits) XOR latched Parity_Type; -> STOP1.
REQ-023 STOP1 bit end: stop error flag set if vote 0; -> STOP2 if latched Two_Stop, else frame complete. STOP2 bit end: flag also set if vote 0; frame complete.
REQ-024 Frame complete SHALL go to IDLE and, on the next cycle, update P_DATA, Parity_Error, Stop_Error registers; Data_Valid=1 that cycle only if both flags 0.
REQ-025 Break (all data votes 0, parity vote 0 if enabled, all stop votes 0) SHALL pulse Break_Detect instead of Data_Valid; Stop_Error still set, P_DATA updated to 0.
REQ-026 Parity_Error and Stop_Error SHALL hold until the next completed frame; glitch-aborted frames SHALL not alter them.
REQ-027 Back-to-back frames: line low on first IDLE cycle after frame complete SHALL start a new frame with no missed bit.
REQ-028 Latency: line falls in cycle 0 -> START occupies cycles 1..OVERSAMPLE; Data_Valid in cycle 1 + OVERSAMPLE*(frame bits incl. start).

Reset
REQ-029 RST high at a rising CLK edge SHALL force IDLE, counters 0, P_DATA 0, shift register 0, Data_Valid 0, Parity_Error 0, Stop_Error 0, Break_Detect 0, Busy 0 the following cycle.
REQ-030 Reset mid-frame SHALL discard the partial frame with no pulse; the next frame after deassertion SHALL be received normally.

Verification (OVERSAMPLE=8, DATA_WIDTH=8)
REQ-031 0xA5, no parity, 1 stop, one mid-bit sample flipped in bit 2 -> Data_Valid only in cycle 81, P_DATA=0xA5, both errors 0.
REQ-032 0x3C, even parity bit 0 -> Data_Valid, Parity_Error=0; same frame with Parity_Type=1 -> Parity_Error=1, no Data_Valid.
REQ-033 Line low 2 cycles then high -> Busy high cycles 1..8, returns IDLE, no pulses, error outputs unchanged.
REQ-034 0x81 with stop bit 0 -> Stop_Error=1, no Data_Valid; line held low 10 bits -> Break_Detect pulse, P_DATA=0x00.
REQ-035 Two_Stop=1, frames 0x55 then 0x0F back-to-back -> two Data_Valid pulses 88 cycles apart, P_DATA 0x55 then 0x0F.
REQ-036 RST asserted in DATA bit 4 -> Busy 0 next cycle, no Data_Valid; following 0xC3 frame -> Data_Valid, P_DATA=0xC3.
